// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - two-port valid/ready to APB master arbiter with timeout watchdog
module apb_master_arbiter #(
    parameter int RR      = 1,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_addr,
    input  logic        req0_write,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_wstrb,
    output logic [31:0] req0_rdata,
    output logic        req0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_addr,
    input  logic        req1_write,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_wstrb,
    output logic [31:0] req1_rdata,
    output logic        req1_err,
    output logic        psel,
    output logic        penable,
    output logic [31:0] paddr,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic [3:0]  pwstrb,
    input  logic        pready,
    input  logic        pslverr,
    input  logic [31:0] prdata
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          psel_q, psel_d;
    logic          pen_q, pen_d;
    logic [31:0]   paddr_q, paddr_d;
    logic          pwrite_q, pwrite_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic [3:0]    pwstrb_q, pwstrb_d;

    logic          gnt_pick;
    logic          timeout_hit;
    logic          done;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    logic          sel_write;

    // On a tie, round-robin hands the bus to the port that did not win last.
    always_comb begin
        gnt_pick = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_pick = (RR != 0) ? ~last_q : 1'b0;
        end else if (req1_valid) begin
            gnt_pick = 1'b1;
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_V);
    assign sel_write   = gnt_pick ? req1_write : req0_write;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        psel_d     = psel_q;
        pen_d      = pen_q;
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        pwstrb_d   = pwstrb_q;
        done       = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_d  = S_SETUP;
                    gnt_d    = gnt_pick;
                    last_d   = gnt_pick;
                    psel_d   = 1'b1;
                    pen_d    = 1'b0;
                    paddr_d  = gnt_pick ? req1_addr : req0_addr;
                    pwrite_d = sel_write;
                    pwdata_d = gnt_pick ? req1_wdata : req0_wdata;
                    pwstrb_d = sel_write ? (gnt_pick ? req1_wstrb : req0_wstrb) : 4'h0;
                end
            end
            S_SETUP: begin
                state_d = S_ACCESS;
                pen_d   = 1'b1;
                cnt_d   = '0;
            end
            S_ACCESS: begin
                // A real completion takes precedence over the watchdog firing.
                if (pready) begin
                    done       = 1'b1;
                    resp_err   = pslverr;
                    resp_rdata = prdata;
                    state_d    = S_IDLE;
                    psel_d     = 1'b0;
                    pen_d      = 1'b0;
                end else if (timeout_hit) begin
                    done     = 1'b1;
                    resp_err = 1'b1;
                    state_d  = S_IDLE;
                    psel_d   = 1'b0;
                    pen_d    = 1'b0;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            psel_q   <= 1'b0;
            pen_q    <= 1'b0;
            paddr_q  <= 32'h0;
            pwrite_q <= 1'b0;
            pwdata_q <= 32'h0;
            pwstrb_q <= 4'h0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            psel_q   <= psel_d;
            pen_q    <= pen_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            pwstrb_q <= pwstrb_d;
        end
    end

    assign req0_ready = done & ~gnt_q;
    assign req1_ready = done & gnt_q;
    assign req0_err   = req0_ready & resp_err;
    assign req1_err   = req1_ready & resp_err;
    assign req0_rdata = req0_ready ? resp_rdata : 32'h0;
    assign req1_rdata = req1_ready ? resp_rdata : 32'h0;

    assign psel    = psel_q;
    assign penable = pen_q;
    assign paddr   = paddr_q;
    assign pwrite  = pwrite_q;
    assign pwdata  = pwdata_q;
    assign pwstrb  = pwstrb_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - scoreboard bench for apb_master_arbiter
module tb_apb_master_arbiter;

    logic clk;
    logic rst_n;

    logic        a_req0_valid, a_req0_ready, a_req0_write, a_req0_err;
    logic [31:0] a_req0_addr, a_req0_wdata, a_req0_rdata;
    logic [3:0]  a_req0_wstrb;
    logic        a_req1_valid, a_req1_ready, a_req1_write, a_req1_err;
    logic [31:0] a_req1_addr, a_req1_wdata, a_req1_rdata;
    logic [3:0]  a_req1_wstrb;
    logic        psel_a, penable_a, pwrite_a, pready_a, pslverr_a;
    logic [31:0] paddr_a, pwdata_a, prdata_a;
    logic [3:0]  pwstrb_a;

    logic        b_req0_valid, b_req0_ready, b_req0_err;
    logic [31:0] b_req0_rdata;
    logic        b_req1_valid, b_req1_ready, b_req1_err;
    logic [31:0] b_req1_rdata;
    logic        psel_b, penable_b, pwrite_b;
    logic [31:0] paddr_b, pwdata_b, prdata_b;
    logic [3:0]  pwstrb_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    int          waits_cfg = 0;
    logic        err_cfg   = 1'b0;
    logic [31:0] rdata_cfg = 32'h0;
    int          wcnt      = 0;

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    apb_master_arbiter #(.RR(1), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_addr(a_req0_addr),
        .req0_write(a_req0_write), .req0_wdata(a_req0_wdata), .req0_wstrb(a_req0_wstrb),
        .req0_rdata(a_req0_rdata), .req0_err(a_req0_err),
        .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_addr(a_req1_addr),
        .req1_write(a_req1_write), .req1_wdata(a_req1_wdata), .req1_wstrb(a_req1_wstrb),
        .req1_rdata(a_req1_rdata), .req1_err(a_req1_err),
        .psel(psel_a), .penable(penable_a), .paddr(paddr_a), .pwrite(pwrite_a),
        .pwdata(pwdata_a), .pwstrb(pwstrb_a), .pready(pready_a), .pslverr(pslverr_a),
        .prdata(prdata_a)
    );

    apb_master_arbiter #(.RR(0), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_addr(32'h0000_0100),
        .req0_write(1'b0), .req0_wdata(32'h0), .req0_wstrb(4'h0),
        .req0_rdata(b_req0_rdata), .req0_err(b_req0_err),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_addr(32'h0000_0200),
        .req1_write(1'b0), .req1_wdata(32'h0), .req1_wstrb(4'h0),
        .req1_rdata(b_req1_rdata), .req1_err(b_req1_err),
        .psel(psel_b), .penable(penable_b), .paddr(paddr_b), .pwrite(pwrite_b),
        .pwdata(pwdata_b), .pwstrb(pwstrb_b), .pready(1'b1), .pslverr(1'b0),
        .prdata(prdata_b)
    );

    assign prdata_b = paddr_b ^ 32'h1111_0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int port, input logic [31:0] addr, input logic wr,
                                input logic [31:0] wdata, input logic [3:0] strb, input logic to_exp);
        exp_t e;
        e.port  = port;
        e.addr  = addr;
        e.write = wr;
        e.wdata = wdata;
        e.strb  = wr ? strb : 4'h0;
        e.rdata = to_exp ? 32'h0 : rdata_cfg;
        e.err   = to_exp ? 1'b1 : err_cfg;
        return e;
    endfunction

    task automatic drive(input int port, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] strb, input logic v);
        if (port == 0) begin
            a_req0_addr = addr; a_req0_write = wr; a_req0_wdata = wdata;
            a_req0_wstrb = strb; a_req0_valid = v;
        end else begin
            a_req1_addr = addr; a_req1_write = wr; a_req1_wdata = wdata;
            a_req1_wstrb = strb; a_req1_valid = v;
        end
    endtask

    task automatic send(input int port, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input logic push_en, input logic to_exp, output int cycles);
        bit got;
        @(negedge clk);
        if (push_en) qa.push_back(mk(port, addr, wr, wdata, strb, to_exp));
        drive(port, addr, wr, wdata, strb, 1'b1);
        got = 0;
        cycles = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            #2;
            if ((port == 0) ? a_req0_ready : a_req1_ready) begin
                got = 1;
                cycles = i + 1;
            end
        end
        check_eq($sformatf("p%0d_ready_seen", port), 32'(got), 32'd1);
        drive(port, addr, wr, wdata, strb, 1'b0);
    endtask

    // Completer model for dut_a: pready after waits_cfg ACCESS cycles.
    always @(negedge clk) begin
        if (psel_a && penable_a) begin
            pready_a = (wcnt >= waits_cfg);
            wcnt++;
        end else begin
            pready_a = 1'b0;
            wcnt = 0;
        end
        prdata_a  = rdata_cfg;
        pslverr_a = err_cfg;
    end

    always @(negedge clk) begin
        #2;
        if (psel_a && penable_a && qa.size() > 0) begin
            check_eq("a_paddr", paddr_a, qa[0].addr);
            check_eq("a_pwrite", 32'(pwrite_a), 32'(qa[0].write));
            check_eq("a_pwdata", pwdata_a, qa[0].wdata);
            check_eq("a_pwstrb", 32'(pwstrb_a), 32'(qa[0].strb));
        end
        if (a_req0_ready || a_req1_ready) begin
            if (qa.size() == 0) begin
                check_eq("a_spurious_ready", {30'd0, a_req1_ready, a_req0_ready}, 32'd0);
            end else begin
                ea = qa.pop_front();
                check_eq("a_ready_port", {30'd0, a_req1_ready, a_req0_ready}, (ea.port == 1) ? 32'd2 : 32'd1);
                check_eq("a_rdata", (ea.port == 1) ? a_req1_rdata : a_req0_rdata, ea.rdata);
                check_eq("a_err", 32'((ea.port == 1) ? a_req1_err : a_req0_err), 32'(ea.err));
                check_eq("a_other_quiet", (ea.port == 1) ? (a_req0_rdata | 32'(a_req0_err))
                                                         : (a_req1_rdata | 32'(a_req1_err)), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (b_req0_ready || b_req1_ready) begin
            if (qb.size() == 0) begin
                check_eq("b_spurious_ready", {30'd0, b_req1_ready, b_req0_ready}, 32'd0);
            end else begin
                eb = qb.pop_front();
                check_eq("b_ready_port", {30'd0, b_req1_ready, b_req0_ready}, (eb.port == 1) ? 32'd2 : 32'd1);
                check_eq("b_rdata", (eb.port == 1) ? b_req1_rdata : b_req0_rdata, eb.rdata);
            end
        end
    end

    int c0, c1, c2, c3, c;
    bit hit;

    initial begin
        rst_n = 1'b0;
        a_req0_valid = 0; a_req0_addr = 0; a_req0_write = 0; a_req0_wdata = 0; a_req0_wstrb = 0;
        a_req1_valid = 0; a_req1_addr = 0; a_req1_write = 0; a_req1_wdata = 0; a_req1_wstrb = 0;
        b_req0_valid = 0; b_req1_valid = 0;
        pready_a = 0; pslverr_a = 0; prdata_a = 0;
        repeat (3) @(negedge clk);
        #2;
        check_eq("rst_psel", 32'(psel_a), 32'd0);
        check_eq("rst_penable", 32'(penable_a), 32'd0);
        check_eq("rst_paddr", paddr_a, 32'd0);
        check_eq("rst_pwdata", pwdata_a, 32'd0);
        check_eq("rst_pwstrb_pwrite", {27'd0, pwstrb_a, pwrite_a}, 32'd0);
        check_eq("rst_ready_err", {28'd0, a_req1_ready, a_req0_ready, a_req1_err, a_req0_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait read on port 0, cycle by cycle.
        waits_cfg = 0; err_cfg = 0; rdata_cfg = 32'hDEAD_BEEF;
        @(negedge clk);
        qa.push_back(mk(0, 32'h1000, 1'b0, 32'h0, 4'hF, 1'b0));
        drive(0, 32'h1000, 1'b0, 32'h0, 4'hF, 1'b1);
        @(negedge clk); #2;
        check_eq("zw_c1_psel_pen", {30'd0, psel_a, penable_a}, 32'd2);
        check_eq("zw_c1_no_ready", 32'(a_req0_ready), 32'd0);
        @(negedge clk); #2;
        check_eq("zw_c2_psel_pen", {30'd0, psel_a, penable_a}, 32'd3);
        check_eq("zw_c2_ready", 32'(a_req0_ready), 32'd1);
        drive(0, 32'h1000, 1'b0, 32'h0, 4'hF, 1'b0);
        @(negedge clk); #2;
        check_eq("zw_c3_psel", 32'(psel_a), 32'd0);

        // Port 1 write with three wait cycles.
        waits_cfg = 3; rdata_cfg = 32'h0BAD_F00D;
        send(1, 32'h2004, 1'b1, 32'hA5A5_A5A5, 4'h3, 1'b1, 1'b0, c);
        check_eq("wr_wait_latency", c, 5);

        // Slave error.
        waits_cfg = 0; err_cfg = 1; rdata_cfg = 32'h7777_0000;
        send(0, 32'h3000, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, c);
        check_eq("slverr_latency", c, 2);
        @(negedge clk); #2;
        check_eq("slverr_back_idle", 32'(psel_a), 32'd0);

        // Timeout with pready held low.
        waits_cfg = 100; err_cfg = 0; rdata_cfg = 32'h5555_AAAA;
        send(0, 32'h3008, 1'b1, 32'h1234_0000, 4'hC, 1'b1, 1'b1, c);
        check_eq("timeout_latency", c, 6);
        @(negedge clk); #2;
        check_eq("timeout_psel_drop", {30'd0, psel_a, penable_a}, 32'd0);

        // pready arrives in the very cycle the watchdog would fire.
        waits_cfg = 4; err_cfg = 0; rdata_cfg = 32'h1234_5678;
        send(1, 32'h300C, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, c);
        check_eq("to_edge_latency", c, 6);

        // Reset while in ACCESS.
        waits_cfg = 100;
        @(negedge clk);
        drive(0, 32'h4000, 1'b0, 32'h0, 4'h0, 1'b1);
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk); #2;
            if (psel_a && penable_a) hit = 1;
        end
        check_eq("rst_mid_reached_access", 32'(hit), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_async_drop", {30'd0, psel_a, penable_a}, 32'd0);
        drive(0, 32'h4000, 1'b0, 32'h0, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Contention on round-robin instance: order 0,1,0,1.
        waits_cfg = 0; err_cfg = 0; rdata_cfg = 32'hCAFE_0001;
        qa.push_back(mk(0, 32'h5000, 1'b1, 32'h1111_1111, 4'hF, 1'b0));
        qa.push_back(mk(1, 32'h6000, 1'b0, 32'h0, 4'h0, 1'b0));
        qa.push_back(mk(0, 32'h5004, 1'b0, 32'h0, 4'h0, 1'b0));
        qa.push_back(mk(1, 32'h6004, 1'b1, 32'h2222_2222, 4'h1, 1'b0));
        fork
            begin
                send(0, 32'h5000, 1'b1, 32'h1111_1111, 4'hF, 1'b0, 1'b0, c0);
                send(0, 32'h5004, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, c1);
            end
            begin
                send(1, 32'h6000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, c2);
                send(1, 32'h6004, 1'b1, 32'h2222_2222, 4'h1, 1'b0, 1'b0, c3);
            end
        join
        check_eq("rr_first_tie_p0_latency", c0, 2);

        // Fixed-priority instance: port 0 wins four times in a row.
        for (int i = 0; i < 4; i++) begin
            eb = mk(0, 32'h100, 1'b0, 32'h0, 4'h0, 1'b0);
            eb.rdata = 32'h1111_0100;
            qb.push_back(eb);
        end
        @(negedge clk);
        b_req0_valid = 1'b1;
        b_req1_valid = 1'b1;
        for (int i = 0; i < 60 && qb.size() > 0; i++) begin
            @(negedge clk); #3;
        end
        b_req0_valid = 1'b0;
        b_req1_valid = 1'b0;
        check_eq("b_all_served", qb.size(), 32'd0);

        repeat (5) @(negedge clk);
        #3;
        check_eq("a_queue_drained", qa.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
